multibyte_add_seq: RTL and testbench

Sequencer that performs NUM_BYTES-wide addition by streaming operand bytes, LSB first, through an 8-bit conditional-sum adder core. It chains the carry between bytes in a register. It sits between the operand source (byte stream with valid/ready) and the result consumer. It accepts one byte pair per cycle and emits one registered sum byte per cycle, with final carry and signed overflow flagged on the last byte.

---
 rtl/multibyte_add_seq_pkg.sv | 25 ++
 rtl/multibyte_add_seq_if.sv | 63 ++++++
 rtl/multibyte_add_seq_cond_sum_add8.sv | 52 +++++
 rtl/multibyte_add_seq.sv | 112 +++++++++++
 tb/tb_multibyte_add_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multibyte_add_seq_pkg.sv
// add_seq_pkg: definitions shared by the multi-byte add sequencer.
//   BYTE_W      : width of one operand byte (8)
//   byte_t      : one operand/result byte
//   seq_state_t : sequencer state (IDLE = next byte is byte 0, BUSY = mid-operand)
//   ovf_calc    : signed overflow of the full-width result, computed from the sign bits
//                 of the most significant byte
// Optional feature macro used across the slice: ADD_SEQ_SUB_EN (subtraction support).
package add_seq_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } seq_state_t;

    // Overflow occurs when both operands share a sign and the result sign differs.
    // y7eff is the Y sign bit after any subtract inversion.
    function automatic logic ovf_calc(input logic x7, input logic y7eff, input logic s7);
        return (x7 == y7eff) && (s7 != x7);
    endfunction

endpackage

// File: rtl/multibyte_add_seq_if.sv
// multibyte_add_seq_if: byte-stream handshake between the operand source, the
// sequencer and the result consumer.
//   in_valid/in_ready            : operand byte handshake
//   in_x, in_y                   : operand bytes, LSB first
//   in_cin                       : carry-in, used on byte 0 only
//   in_sub                       : subtract request, byte 0 only (only with ADD_SEQ_SUB_EN)
//   out_valid/out_ready          : result byte handshake
//   out_sum                      : result byte
//   out_last, out_cout, out_ovf  : final-byte marker and flags
// Modports: master = source/consumer side, slave = sequencer side.
interface multibyte_add_seq_if;
    import add_seq_pkg::*;

    logic  in_valid;
    logic  in_ready;
    byte_t in_x;
    byte_t in_y;
    logic  in_cin;
`ifdef ADD_SEQ_SUB_EN
    logic  in_sub;
`endif
    logic  out_valid;
    logic  out_ready;
    byte_t out_sum;
    logic  out_last;
    logic  out_cout;
    logic  out_ovf;

    modport master (
        output in_valid,
        output in_x,
        output in_y,
        output in_cin,
`ifdef ADD_SEQ_SUB_EN
        output in_sub,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_last,
        input  out_cout,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  in_y,
        input  in_cin,
`ifdef ADD_SEQ_SUB_EN
        input  in_sub,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_last,
        output out_cout,
        output out_ovf
    );

endinterface

// File: rtl/multibyte_add_seq_cond_sum_add8.sv
// cond_sum_add8: purely combinational 8-bit conditional-sum adder.
//   a, b : addends
//   cin  : carry-in
//   sum  : a + b + cin (low 8 bits)
//   cout : carry-out
// Every group keeps two candidate results, one assuming a carry-in of 0 and one
// assuming 1. Adjacent groups are merged log2(8)=3 times, the low group's carry
// choosing which candidate of the high group survives; cin makes the final pick.
module cond_sum_add8
    import add_seq_pkg::*;
(
    input  byte_t a,
    input  byte_t b,
    input  logic  cin,
    output byte_t sum,
    output logic  cout
);

    // s0/s1 hold per-bit sums for carry-in 0/1 of each current group; c0/c1 hold
    // group carries indexed by group number.
    always_comb begin
        byte_t s0, s1, c0, c1;
        byte_t n0, n1, nc0, nc1;
        s0 = a ^ b;
        s1 = ~(a ^ b);
        c0 = a & b;
        c1 = a | b;
        for (int lvl = 0; lvl < 3; lvl++) begin
            n0  = s0;
            n1  = s1;
            nc0 = c0;
            nc1 = c1;
            for (int g = 0; g < (BYTE_W >> (lvl + 1)); g++) begin
                for (int k = 0; k < (1 << lvl); k++) begin
                    n0[(2*g+1)*(1<<lvl)+k] = c0[2*g] ? s1[(2*g+1)*(1<<lvl)+k]
                                                     : s0[(2*g+1)*(1<<lvl)+k];
                    n1[(2*g+1)*(1<<lvl)+k] = c1[2*g] ? s1[(2*g+1)*(1<<lvl)+k]
                                                     : s0[(2*g+1)*(1<<lvl)+k];
                end
                nc0[g] = c0[2*g] ? c1[2*g+1] : c0[2*g+1];
                nc1[g] = c1[2*g] ? c1[2*g+1] : c0[2*g+1];
            end
            s0 = n0;
            s1 = n1;
            c0 = nc0;
            c1 = nc1;
        end
        sum  = cin ? s1 : s0;
        cout = cin ? c1[0] : c0[0];
    end

endmodule

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: NUM_BYTES-wide adder that streams operand bytes LSB first
// through one 8-bit conditional-sum core, chaining the carry in a register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : multibyte_add_seq_if.slave (operand input and result output handshakes)
// Parameter NUM_BYTES (2..16): operand width in bytes.
// Macro ADD_SEQ_SUB_EN: adds in_sub; a subtract inverts Y for every byte of the
// operand and forces the byte-0 carry-in to 1 (out_cout=1 then means no borrow).
module multibyte_add_seq
    import add_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multibyte_add_seq_if.slave   bus
);

    localparam int              CNT_W    = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] byte_cnt;
    logic             carry_reg;
    logic             accept;
    logic             is_last;
    logic             core_cin;
    byte_t            y_eff;
    byte_t            core_sum;
    logic             core_cout;

`ifdef ADD_SEQ_SUB_EN
    logic sub_reg;
    logic sub_eff;
`endif

    // A full output register that is being drained in the same cycle can still
    // take a new byte, so the stream never bubbles.
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_last      = (byte_cnt == LAST_IDX);

    // Byte 0 takes its carry (and subtract mode) straight from the inputs; later
    // bytes use the values registered when byte 0 was accepted.
`ifdef ADD_SEQ_SUB_EN
    assign sub_eff  = (state == IDLE) ? bus.in_sub : sub_reg;
    assign y_eff    = sub_eff ? ~bus.in_y : bus.in_y;
    assign core_cin = (state == IDLE) ? (bus.in_sub | bus.in_cin) : carry_reg;
`else
    assign y_eff    = bus.in_y;
    assign core_cin = (state == IDLE) ? bus.in_cin : carry_reg;
`endif

    cond_sum_add8 u_core (
        .a    (bus.in_x),
        .b    (y_eff),
        .cin  (core_cin),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Sequencer state plus the registered output stage. Flags are only non-zero
    // while the final byte of an operand is held in the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            carry_reg     <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_reg       <= 1'b0;
`endif
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= core_sum;
            if (is_last) begin
                bus.out_last <= 1'b1;
                bus.out_cout <= core_cout;
                bus.out_ovf  <= ovf_calc(bus.in_x[BYTE_W-1], y_eff[BYTE_W-1],
                                         core_sum[BYTE_W-1]);
                byte_cnt     <= '0;
                state        <= IDLE;
                carry_reg    <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
                sub_reg      <= 1'b0;
`endif
            end else begin
                bus.out_last <= 1'b0;
                bus.out_cout <= 1'b0;
                bus.out_ovf  <= 1'b0;
                byte_cnt     <= byte_cnt + 1'b1;
                state        <= BUSY;
                carry_reg    <= core_cout;
`ifdef ADD_SEQ_SUB_EN
                if (state == IDLE) begin
                    sub_reg <= bus.in_sub;
                end
`endif
            end
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_cout  <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb_multibyte_add_seq: directed self-checking bench for multibyte_add_seq with
// NUM_BYTES=4. Inputs change and outputs are sampled on the falling clock edge.
// The subtraction scenario is present only when ADD_SEQ_SUB_EN is defined.
module tb_multibyte_add_seq;
    import add_seq_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    multibyte_add_seq_if bus ();

    multibyte_add_seq #(.NUM_BYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Streams one 32-bit operand pair with out_ready high, one byte per cycle,
    // and records what the output register shows the cycle after each accept.
    // Later bytes drive in_cin (and in_sub) inverted to expose any use of them.
    task automatic stream_operand(input logic [31:0] x, input logic [31:0] y,
                                  input logic cin, input logic sub,
                                  output logic [31:0] got_sum, output logic [3:0] got_valid,
                                  output logic [3:0] got_last, output logic got_cout,
                                  output logic got_ovf, output logic early_flag);
        early_flag = 1'b0;
        got_cout   = 1'b0;
        got_ovf    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = x[8*i +: 8];
            bus.in_y     = y[8*i +: 8];
            bus.in_cin   = (i == 0) ? cin : ~cin;
`ifdef ADD_SEQ_SUB_EN
            bus.in_sub   = (i == 0) ? sub : ~sub;
`endif
            @(negedge clk);
            got_sum[8*i +: 8] = bus.out_sum;
            got_valid[i]      = bus.out_valid;
            got_last[i]       = bus.out_last;
            if (i == 3) begin
                got_cout = bus.out_cout;
                got_ovf  = bus.out_ovf;
            end else begin
                early_flag = early_flag | bus.out_cout | bus.out_ovf;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_cin   = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.in_sub   = 1'b0;
`else
        if (sub) $display("[TB] note: subtract request ignored in this build");
`endif
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = 8'h00;
        bus.in_y      = 8'h00;
        bus.in_cin    = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if (bus.out_sum !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_out_sum got=%h want=00", bus.out_sum);
        end
        total++;
        if ({bus.out_last, bus.out_cout, bus.out_ovf} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b want=000",
                     {bus.out_last, bus.out_cout, bus.out_ovf});
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    // One directed add: every byte valid, last only on byte 3, flags only on byte 3.
    task automatic test_add(input string name, input logic [31:0] x, input logic [31:0] y,
                            input logic cin, input logic sub, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
        logic [31:0] s;
        logic [3:0]  v, l;
        logic        c, o, e;
        stream_operand(x, y, cin, sub, s, v, l, c, o, e);
        total++;
        if (s !== exp_sum) begin
            bad++;
            $display("[TB] FAIL %s_sum got=%h want=%h", name, s, exp_sum);
        end
        total++;
        if (v !== 4'b1111) begin
            bad++;
            $display("[TB] FAIL %s_valid got=%b want=1111", name, v);
        end
        total++;
        if (l !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL %s_last got=%b want=1000", name, l);
        end
        total++;
        if (c !== exp_cout) begin
            bad++;
            $display("[TB] FAIL %s_cout got=%b want=%b", name, c, exp_cout);
        end
        total++;
        if (o !== exp_ovf) begin
            bad++;
            $display("[TB] FAIL %s_ovf got=%b want=%b", name, o, exp_ovf);
        end
        total++;
        if (e !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_early_flags got=%b want=0", name, e);
        end
    endtask

    task automatic test_arith();
        test_add("add_ff_01",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        test_add("add_wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        test_add("add_pos_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        test_add("add_cin",     32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
        test_add("add_neg_ovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    endtask

    // Two operands with no gap, then an idle cycle must drain the output.
    task automatic test_back_to_back();
        test_add("b2b_first",  32'h01020304, 32'h10203040, 1'b0, 1'b0, 32'h11223344, 1'b0, 1'b0);
        test_add("b2b_second", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_drain got valid=%b last=%b want valid=0 last=0",
                     bus.out_valid, bus.out_last);
        end
    endtask

    task automatic test_backpressure();
        bus.in_valid = 1'b1;
        bus.in_x     = 8'h01;
        bus.in_y     = 8'h01;
        bus.in_cin   = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h02) begin
            bad++;
            $display("[TB] FAIL bp_byte0 got valid=%b sum=%h want valid=1 sum=02",
                     bus.out_valid, bus.out_sum);
        end
        bus.out_ready = 1'b0;
        bus.in_x      = 8'h00;
        bus.in_y      = 8'h00;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_sum !== 8'h02
                || bus.out_last !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d got rdy=%b valid=%b sum=%h last=%b want rdy=0 valid=1 sum=02 last=0",
                         c, bus.in_ready, bus.out_valid, bus.out_sum, bus.out_last);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h00
                || bus.out_last !== (i == 3) || bus.out_cout !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_byte%0d got valid=%b sum=%h last=%b cout=%b want valid=1 sum=00 last=%b cout=0",
                         i, bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout, (i == 3));
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Reset two bytes into an operand that leaves a carry pending.
    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_cin   = 1'b0;
        bus.in_x     = 8'hFF;
        bus.in_y     = 8'h01;
        @(negedge clk);
        bus.in_x     = 8'hFF;
        bus.in_y     = 8'h00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_sum !== 8'h00) begin
            bad++;
            $display("[TB] FAIL midrst_flush got valid=%b sum=%h want valid=0 sum=00",
                     bus.out_valid, bus.out_sum);
        end
        test_add("midrst_next", 32'h00000001, 32'h00000001, 1'b0, 1'b0,
                 32'h00000002, 1'b0, 1'b0);
    endtask

`ifdef ADD_SEQ_SUB_EN
    // in_cin is driven high on byte 0 and must be overridden by the subtract.
    task automatic test_sub();
        test_add("sub_5_7", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        test_add("sub_9_2", 32'h00000009, 32'h00000002, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
